mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Parametrised, multi-cycle data-memory access unit for the MEM stage of the OpenMIPS pipeline. It replaces single-cycle combinational RAM access with a req/ack bus handshake that tolerates wait states. It stalls the pipeline while a transfer is outstanding and reports address-error, bus-error and timeout exceptions. Data width is configurable to 32 or 64 bits with big-endian byte lanes.

## Interface
- DATA_W, 32, data bus width; 32 or 64 only.
- ADDR_W, 32, address width.
- TIMEOUT, 255, max cycles in REQ before a timeout bus error; 1..65535.
- NB (local), DATA_W/8, byte lanes.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req_valid_i  in  1  MEM-stage access request; held with op/addr/wdata stable until done_o or flush_i.
- op_i  in  4  {store, unsigned, size[1:0]}; size 0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
- addr_i  in  ADDR_W  byte address.
- wdata_i  in  DATA_W  store data, right-justified.
- flush_i  in  1  pipeline flush (exception/eret).
- stall_o  out  1  stall request to ctrl.
- done_o  out  1  one-cycle completion pulse.
- rdata_o  out  DATA_W  extended load data, valid with done_o.
- exc_o  out  1  exception flag, valid with done_o.
- exc_code_o  out  5  0x04 AdEL, 0x05 AdES, 0x07 DBE.
- badvaddr_o  out  ADDR_W  faulting address, valid with exc_o.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_addr_o  out  ADDR_W  bus address, aligned down to NB.
- bus_sel_o  out  NB  byte enables; bit NB-1 is byte offset 0.
- bus_wdata_o  out  DATA_W  store data, replicated across lanes.
- bus_ack_i  in  1  transfer complete; bus_rdata_i is valid this cycle.
- bus_rdata_i  in  DATA_W  read data.
- bus_err_i  in  1  bus error; terminates the transfer.

## Operation
- States: IDLE, REQ, DONE, DRAIN.
- Alignment: bytes are always aligned. Half requires addr[0]=0. Word requires addr[1:0]=0. Dword requires addr[2:0]=0. size=3 with DATA_W=32 is treated as misaligned.
- Byte lanes: offset k = addr mod NB maps to lane NB-1-k, bits [8(NB-1-k)+7 : 8(NB-1-k)]. bus_sel_o has a contiguous field of size-many ones starting at lane NB-1-k.
- IDLE with req_valid_i and aligned: register bus_addr/we/sel/wdata, then go to REQ.
- IDLE with req_valid_i and misaligned: no bus cycle; go to DONE with exc_o=1, code 0x04 for a load or 0x05 for a store, and badvaddr=addr_i.
- REQ: bus_req_o=1, and all bus outputs are held constant.
  - bus_ack_i: capture read data, go to DONE.
  - bus_err_i, or counter reaching TIMEOUT: go to DONE with code 0x07 and badvaddr=addr.
  - bus_err_i has priority over bus_ack_i when both are asserted in the same cycle.
- DONE: done_o=1 and stall_o=0. Always returns to IDLE; req_valid_i is ignored in this cycle.
- Load data: the selected lanes are zero-extended when unsigned=1, otherwise sign-extended from the top bit of the field. Store results have rdata_o=0.
- flush_i in IDLE or DONE: go to IDLE, no done_o.
- flush_i in REQ: keep bus_req_o until ack/err/timeout, then go to DRAIN. This avoids abandoning a started bus cycle. No done_o and no exception are reported.
- DRAIN: bus_req_o=0, then IDLE next cycle.
- Counter: 16-bit, cleared on entry to REQ, incremented each REQ cycle without ack/err.

## Timing
- Reset: state IDLE; all outputs 0 (stall_o, done_o, rdata_o, exc_o, exc_code_o, badvaddr_o, bus_*_o). Counter is 0. A reset mid-transfer drops bus_req_o the next cycle.
- stall_o is combinational: (IDLE & req_valid_i & ~flush_i) | REQ | DRAIN.
- Zero-wait-state access (ack in first REQ cycle):
  - cycle 0 IDLE accept;
  - cycle 1 REQ+ack;
  - cycle 2 DONE.
  - Total 3 cycles, with stall for 2.
- Each extra wait cycle adds 1 to the access.
- Misaligned access: IDLE, then DONE; the bus is untouched.
- Timeout: DONE follows the REQ cycle in which the counter equals TIMEOUT.
- Back-to-back requests: the earliest next acceptance is the cycle after DONE.

## Test plan
- DATA_W=32, LW at 0x100, ack after 2 waits, bus_rdata=0x8899AABB -> bus_sel=1111; stall high for 4 cycles; done_o with rdata_o=0x8899AABB, exc_o=0.
- LB at 0x103, bus_rdata=0x000000F0 -> sel=0001, rdata_o=0xFFFFFFF0. LBU at the same address -> rdata_o=0x000000F0.
- SH at 0x202, wdata=0x1234 -> bus_we=1, sel=0011, bus_wdata=0x12341234, bus_addr=0x200.
- LW at 0x101 -> no bus_req; done_o next cycle with exc_code=0x04, badvaddr=0x101. SW at 0x102 -> exc_code=0x05.
- TIMEOUT=4 with no ack -> bus_req held 5 cycles; done_o with exc_code=0x07. A bus_err_i plus bus_ack_i in the same cycle -> 0x07.
- flush_i in the second REQ cycle, ack 3 cycles later -> bus_req held until ack, then DRAIN then IDLE; done_o never asserted. DATA_W=64 LD at 0x8 -> sel=0xFF. LWU-style load (unsigned word) at 0xC returns low lanes zero-extended.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: req/ack bus handshake with wait states,
// big-endian byte lanes, address-error / bus-error / timeout exception reporting.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid_i,
  input  logic [3:0]          op_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic                flush_i,
  output logic                stall_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                exc_o,
  output logic [4:0]          exc_code_o,
  output logic [ADDR_W-1:0]   badvaddr_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic                bus_ack_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_err_i
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, DRAIN = 2'd3} state_e;

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              flush_pend_q, flush_pend_d;
  logic              bus_req_q, bus_req_d;
  logic              bus_we_q, bus_we_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [NB-1:0]     bus_sel_q, bus_sel_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              exc_q, exc_d;
  logic [4:0]        exc_code_q, exc_code_d;
  logic [ADDR_W-1:0] badvaddr_q, badvaddr_d;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] a);
    logic ok;
    case (size)
      2'd0:    ok = 1'b1;
      2'd1:    ok = (a[0] == 1'b0);
      2'd2:    ok = (a[1:0] == 2'b00);
      2'd3:    ok = (DATA_W == 64) && (a == 3'b000);
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Offset k lands on lane NB-1-k; the field then extends toward lane 0.
  function automatic logic [NB-1:0] lane_sel(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [NB-1:0] sel;
    int hi;
    int lo;
    hi = NB - 1 - int'(off);
    lo = hi + 1 - (1 << size);
    for (int i = 0; i < NB; i++) begin
      sel[i] = (i >= lo) && (i <= hi);
    end
    return sel;
  endfunction

  function automatic logic [DATA_W-1:0] replicate(input logic [1:0] size, input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] r;
    case (size)
      2'd0:    r = {NB{w[7:0]}};
      2'd1:    r = {(NB/2){w[15:0]}};
      2'd2:    r = {(NB/4){w[31:0]}};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] rd, input logic [1:0] size,
                                                    input logic uns, input logic [OFF_W-1:0] off);
    logic [DATA_W-1:0] field;
    logic [DATA_W-1:0] mask;
    logic              sgn;
    field = rd >> (8 * (NB - int'(off) - (1 << size)));
    mask  = {DATA_W{1'b1}} >> (DATA_W - 8 * (1 << size));
    case (size)
      2'd0:    sgn = field[7];
      2'd1:    sgn = field[15];
      2'd2:    sgn = field[31];
      default: sgn = field[DATA_W-1];
    endcase
    field = field & mask;
    return (!uns && sgn) ? (field | ~mask) : field;
  endfunction

  // Next-state and next-register computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    flush_pend_d = flush_pend_q;
    bus_req_d    = bus_req_q;
    bus_we_d     = bus_we_q;
    bus_addr_d   = bus_addr_q;
    bus_sel_d    = bus_sel_q;
    bus_wdata_d  = bus_wdata_q;
    size_d       = size_q;
    uns_d        = uns_q;
    off_d        = off_q;
    addr_d       = addr_q;
    rdata_d      = rdata_q;
    exc_d        = exc_q;
    exc_code_d   = exc_code_q;
    badvaddr_d   = badvaddr_q;
    case (state_q)
      IDLE: begin
        if (req_valid_i && !flush_i) begin
          if (is_aligned(op_i[1:0], addr_i[2:0])) begin
            bus_req_d    = 1'b1;
            bus_we_d     = op_i[3];
            bus_addr_d   = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            bus_sel_d    = lane_sel(op_i[1:0], addr_i[OFF_W-1:0]);
            bus_wdata_d  = replicate(op_i[1:0], wdata_i);
            size_d       = op_i[1:0];
            uns_d        = op_i[2];
            off_d        = addr_i[OFF_W-1:0];
            addr_d       = addr_i;
            cnt_d        = 16'd0;
            flush_pend_d = 1'b0;
            state_d      = REQ;
          end else begin
            exc_d      = 1'b1;
            exc_code_d = op_i[3] ? 5'h05 : 5'h04;
            badvaddr_d = addr_i;
            rdata_d    = {DATA_W{1'b0}};
            state_d    = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        flush_pend_d = flush_pend_q | flush_i;
        if (bus_err_i || bus_ack_i || (cnt_q == TIMEOUT_CNT)) begin
          bus_req_d   = 1'b0;
          bus_we_d    = 1'b0;
          bus_addr_d  = {ADDR_W{1'b0}};
          bus_sel_d   = {NB{1'b0}};
          bus_wdata_d = {DATA_W{1'b0}};
          if (flush_pend_q || flush_i) begin
            state_d = DRAIN;
          end else if (!bus_err_i && bus_ack_i) begin
            rdata_d = bus_we_q ? {DATA_W{1'b0}} : extend_load(bus_rdata_i, size_q, uns_q, off_q);
            exc_d   = 1'b0;
            state_d = DONE;
          end else begin
            // Error wins over a simultaneous ack; a timeout is reported the same way.
            exc_d      = 1'b1;
            exc_code_d = 5'h07;
            badvaddr_d = addr_q;
            rdata_d    = {DATA_W{1'b0}};
            state_d    = DONE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DONE: begin
        rdata_d    = {DATA_W{1'b0}};
        exc_d      = 1'b0;
        exc_code_d = 5'h00;
        badvaddr_d = {ADDR_W{1'b0}};
        state_d    = IDLE;
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= 16'd0;
      flush_pend_q <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= {ADDR_W{1'b0}};
      bus_sel_q    <= {NB{1'b0}};
      bus_wdata_q  <= {DATA_W{1'b0}};
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      off_q        <= {OFF_W{1'b0}};
      addr_q       <= {ADDR_W{1'b0}};
      rdata_q      <= {DATA_W{1'b0}};
      exc_q        <= 1'b0;
      exc_code_q   <= 5'h00;
      badvaddr_q   <= {ADDR_W{1'b0}};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      flush_pend_q <= flush_pend_d;
      bus_req_q    <= bus_req_d;
      bus_we_q     <= bus_we_d;
      bus_addr_q   <= bus_addr_d;
      bus_sel_q    <= bus_sel_d;
      bus_wdata_q  <= bus_wdata_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      off_q        <= off_d;
      addr_q       <= addr_d;
      rdata_q      <= rdata_d;
      exc_q        <= exc_d;
      exc_code_q   <= exc_code_d;
      badvaddr_q   <= badvaddr_d;
    end
  end

  assign stall_o     = ((state_q == IDLE) && req_valid_i && !flush_i) || (state_q == REQ) || (state_q == DRAIN);
  assign done_o      = (state_q == DONE) && !flush_i;
  assign rdata_o     = rdata_q;
  assign exc_o       = exc_q;
  assign exc_code_o  = exc_code_q;
  assign badvaddr_o  = badvaddr_q;
  assign bus_req_o   = bus_req_q;
  assign bus_we_o    = bus_we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: a 32-bit (TIMEOUT=4) and a 64-bit (TIMEOUT=7)
// instance checked against a byte-level behavioural model of the access rules.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, flush, bus_ack, bus_err;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [63:0] wdata, bus_rdata;
  bit          cur64;

  logic        a_stall, a_done, a_exc, a_req, a_we;
  logic [31:0] a_rdata, a_bad, a_baddr, a_bwdata;
  logic [4:0]  a_code;
  logic [3:0]  a_sel;
  logic        b_stall, b_done, b_exc, b_req, b_we;
  logic [63:0] b_rdata, b_bwdata;
  logic [31:0] b_bad, b_baddr;
  logic [4:0]  b_code;
  logic [7:0]  b_sel;

  logic        o_stall, o_done, o_exc, o_req, o_we;
  logic [63:0] o_rdata, o_bwdata;
  logic [31:0] o_bad, o_baddr;
  logic [4:0]  o_code;
  logic [7:0]  o_sel;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid & ~cur64), .op_i(op), .addr_i(addr),
    .wdata_i(wdata[31:0]), .flush_i(flush), .stall_o(a_stall), .done_o(a_done), .rdata_o(a_rdata),
    .exc_o(a_exc), .exc_code_o(a_code), .badvaddr_o(a_bad), .bus_req_o(a_req), .bus_we_o(a_we),
    .bus_addr_o(a_baddr), .bus_sel_o(a_sel), .bus_wdata_o(a_bwdata), .bus_ack_i(bus_ack),
    .bus_rdata_i(bus_rdata[31:0]), .bus_err_i(bus_err));

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(7)) u_dut64 (
    .clk(clk), .rst(rst), .req_valid_i(req_valid & cur64), .op_i(op), .addr_i(addr),
    .wdata_i(wdata), .flush_i(flush), .stall_o(b_stall), .done_o(b_done), .rdata_o(b_rdata),
    .exc_o(b_exc), .exc_code_o(b_code), .badvaddr_o(b_bad), .bus_req_o(b_req), .bus_we_o(b_we),
    .bus_addr_o(b_baddr), .bus_sel_o(b_sel), .bus_wdata_o(b_bwdata), .bus_ack_i(bus_ack),
    .bus_rdata_i(bus_rdata), .bus_err_i(bus_err));

  always_comb begin
    o_stall  = cur64 ? b_stall  : a_stall;
    o_done   = cur64 ? b_done   : a_done;
    o_exc    = cur64 ? b_exc    : a_exc;
    o_req    = cur64 ? b_req    : a_req;
    o_we     = cur64 ? b_we     : a_we;
    o_rdata  = cur64 ? b_rdata  : {32'd0, a_rdata};
    o_bwdata = cur64 ? b_bwdata : {32'd0, a_bwdata};
    o_bad    = cur64 ? b_bad    : a_bad;
    o_baddr  = cur64 ? b_baddr  : a_baddr;
    o_code   = cur64 ? b_code   : a_code;
    o_sel    = cur64 ? b_sel    : {4'd0, a_sel};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---- reference model: plain byte arithmetic over the big-endian lane map ----
  function automatic bit m_misaligned(input bit w64, input logic [3:0] o, input logic [31:0] a);
    int n = 1 << o[1:0];
    return (o[1:0] == 2'd3 && !w64) || ((a % n) != 0);
  endfunction

  function automatic logic [7:0] m_sel(input bit w64, input logic [3:0] o, input logic [31:0] a);
    int lanes = w64 ? 8 : 4;
    int k = a % lanes;
    logic [7:0] s = 8'd0;
    for (int j = 0; j < (1 << o[1:0]); j++) s[lanes-1-k-j] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] m_wdata(input bit w64, input logic [3:0] o, input logic [63:0] w);
    int lanes = w64 ? 8 : 4;
    int n = 1 << o[1:0];
    logic [63:0] r = 64'd0;
    for (int l = 0; l < lanes; l++) begin
      int ofs = lanes - 1 - l;
      r[8*l +: 8] = w[8*(n-1-(ofs % n)) +: 8];
    end
    return r;
  endfunction

  function automatic logic [63:0] m_load(input bit w64, input logic [3:0] o, input logic [31:0] a,
                                         input logic [63:0] rd);
    int lanes = w64 ? 8 : 4;
    int k = a % lanes;
    int n = 1 << o[1:0];
    logic [63:0] v = 64'd0;
    if (o[3]) return 64'd0;
    for (int j = 0; j < n; j++) v = (v << 8) | {56'd0, rd[8*(lanes-1-k-j) +: 8]};
    if (!o[2] && v[8*n-1]) begin
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    end
    if (!w64) v[63:32] = 32'd0;
    return v;
  endfunction

  task automatic run_access(input bit w64, input logic [3:0] o, input logic [31:0] a,
                            input logic [63:0] wd, input logic [63:0] rd,
                            input int waits, input bit err, input bit noack);
    int  tmo = w64 ? 7 : 4;
    bit  mis = m_misaligned(w64, o, a);
    bit  seen = 1'b0;
    int  req_cyc = 0;
    int  exp_cyc;
    @(negedge clk);
    cur64 = w64; req_valid = 1'b1; op = o; addr = a; wdata = wd; bus_rdata = rd;
    bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
    #1;
    check_eq("stall_accept", o_stall, 1'b1);
    check_eq("busreq_idle", o_req, 1'b0);
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      bus_ack = !mis && (c == waits) && !noack;
      bus_err = !mis && (c == waits) && err;
      #1;
      if (o_done) begin
        seen = 1'b1;
      end else begin
        req_cyc++;
        check_eq("busreq_req", o_req, 1'b1);
        check_eq("stall_req", o_stall, 1'b1);
        check_eq("bus_we", o_we, o[3]);
        check_eq("bus_addr", o_baddr, a & (w64 ? ~32'd7 : ~32'd3));
        check_eq("bus_sel", o_sel, m_sel(w64, o, a));
        check_eq("bus_wdata", o_bwdata, m_wdata(w64, o, wd));
      end
    end
    exp_cyc = mis ? 0 : (err ? waits + 1 : (noack ? tmo + 1 : waits + 1));
    check_eq("done_seen", seen, 1'b1);
    check_eq("req_cycles", req_cyc, exp_cyc);
    check_eq("stall_done", o_stall, 1'b0);
    check_eq("busreq_done", o_req, 1'b0);
    if (mis) begin
      check_eq("exc", o_exc, 1'b1);
      check_eq("exc_code", o_code, o[3] ? 5'h05 : 5'h04);
      check_eq("badvaddr", o_bad, a);
    end else if (err || noack) begin
      check_eq("exc", o_exc, 1'b1);
      check_eq("exc_code", o_code, 5'h07);
      check_eq("badvaddr", o_bad, a);
    end else begin
      check_eq("exc", o_exc, 1'b0);
      check_eq("rdata", o_rdata, m_load(w64, o, a, rd));
    end
    bus_ack = 1'b0; bus_err = 1'b0;
  endtask

  task automatic run_flush(input bit w64, input logic [3:0] o, input logic [31:0] a, input int f, input int waits);
    @(negedge clk);
    cur64 = w64; req_valid = 1'b1; op = o; addr = a; wdata = 64'h0; bus_rdata = 64'h5A;
    bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
    for (int c = 0; c <= waits; c++) begin
      @(negedge clk);
      flush = (c == f);
      req_valid = (c <= f);
      bus_ack = (c == waits);
      #1;
      check_eq("fl_busreq", o_req, 1'b1);
      check_eq("fl_done", o_done, 1'b0);
    end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0; bus_ack = 1'b0;
    #1;
    check_eq("drain_busreq", o_req, 1'b0);
    check_eq("drain_stall", o_stall, 1'b1);
    check_eq("drain_done", o_done, 1'b0);
    @(negedge clk);
    #1;
    check_eq("postdrain_stall", o_stall, 1'b0);
    check_eq("postdrain_done", o_done, 1'b0);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra;
    bit          rw;
    int          w;
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; bus_ack = 1'b0; bus_err = 1'b0;
    op = 4'd0; addr = 32'd0; wdata = 64'd0; bus_rdata = 64'd0; cur64 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_a_outs", {a_stall, a_done, a_exc, a_req, a_we, a_code, a_sel}, 64'd0);
    check_eq("rst_a_data", {a_rdata, a_bad}, 64'd0);
    check_eq("rst_a_bus", {a_baddr, a_bwdata}, 64'd0);
    check_eq("rst_b_outs", {b_stall, b_done, b_exc, b_req, b_we, b_code, b_sel}, 64'd0);
    check_eq("rst_b_data", b_rdata | {32'd0, b_bad}, 64'd0);
    check_eq("rst_b_bus", b_bwdata | {32'd0, b_baddr}, 64'd0);
    rst = 1'b0;

    // directed cases from the access rules
    run_access(1'b0, 4'b0010, 32'h100, 64'h0, 64'h8899AABB, 2, 1'b0, 1'b0);
    check_eq("lw_literal", o_rdata, 64'h8899AABB);
    run_access(1'b0, 4'b0000, 32'h103, 64'h0, 64'h000000F0, 0, 1'b0, 1'b0);
    check_eq("lb_literal", o_rdata, 64'hFFFFFFF0);
    run_access(1'b0, 4'b0100, 32'h103, 64'h0, 64'h000000F0, 1, 1'b0, 1'b0);
    run_access(1'b0, 4'b1001, 32'h202, 64'h1234, 64'h0, 0, 1'b0, 1'b0);
    run_access(1'b0, 4'b0010, 32'h101, 64'h0, 64'h0, 0, 1'b0, 1'b0);
    run_access(1'b0, 4'b1010, 32'h102, 64'h0, 64'h0, 0, 1'b0, 1'b0);
    run_access(1'b0, 4'b0011, 32'h108, 64'h0, 64'h0, 0, 1'b0, 1'b0);
    run_access(1'b0, 4'b0010, 32'h300, 64'h0, 64'h0, 0, 1'b0, 1'b1);
    run_access(1'b0, 4'b0010, 32'h304, 64'h0, 64'h0, 1, 1'b1, 1'b0);
    run_access(1'b0, 4'b0001, 32'h306, 64'h0, 64'h0, 2, 1'b1, 1'b1);
    run_flush(1'b0, 4'b0010, 32'h400, 1, 4);
    run_access(1'b1, 4'b0011, 32'h8, 64'h0, 64'h0123456789ABCDEF, 0, 1'b0, 1'b0);
    run_access(1'b1, 4'b0110, 32'hC, 64'h0, 64'hFEDCBA98_87654321, 1, 1'b0, 1'b0);
    check_eq("lwu_literal", o_rdata, 64'h0000000087654321);
    run_access(1'b1, 4'b0010, 32'h20, 64'h0, 64'h0, 0, 1'b0, 1'b1);

    // flush in IDLE blocks acceptance
    @(negedge clk);
    cur64 = 1'b0; req_valid = 1'b1; flush = 1'b1; op = 4'b0010; addr = 32'h40;
    #1 check_eq("idleflush_stall", o_stall, 1'b0);
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    #1 check_eq("idleflush_busreq", o_req, 1'b0);

    // reset mid-transfer drops the bus request
    @(negedge clk);
    cur64 = 1'b0; req_valid = 1'b1; op = 4'b0010; addr = 32'h80;
    repeat (2) @(negedge clk);
    #1 check_eq("midrst_pre", o_req, 1'b1);
    rst = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    #1 check_eq("midrst_busreq", o_req, 1'b0);
    check_eq("midrst_stall", o_stall, 1'b0);
    rst = 1'b0;

    // randomized accesses
    for (int i = 0; i < 80; i++) begin
      rw = 1'($urandom_range(0, 1));
      ro = 4'($urandom_range(0, 15));
      if (!rw && ro[1:0] == 2'd3 && $urandom_range(0, 3) != 0) ro[1:0] = 2'd2;
      ra = $urandom & 32'h0000FFF8;
      if ($urandom_range(0, 3) == 0) ra = ra | 32'($urandom_range(0, 7));
      else ra = ra | (32'($urandom_range(0, 7)) & ~((32'd1 << ro[1:0]) - 32'd1));
      w = $urandom_range(0, 3);
      run_access(rw, ro, ra, {$urandom, $urandom}, {$urandom, $urandom}, w,
                 ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 9) == 0) run_flush(rw, {2'b00, 2'($urandom_range(0, 1))}, ra & ~32'd7, 0, w + 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
